// File: rtl/conv2d_1_filter_scheduler.sv
// conv2d_1_filter_scheduler: lockstep input pop for a bank of filter cores
// and per-filter output buffering, drained in strict round-robin order.
module conv2d_1_filter_scheduler #(
  parameter int DWIDTH      = 32,
  parameter int NUM_FILTERS = 8,
  parameter int BUF_DEPTH   = 8,
  parameter int STALL_LEVEL = 4,
  parameter int FRAME_WORDS = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    ff_empty,
  output logic                          ff_rdreq,
  output logic                          core_empty,
  input  logic [NUM_FILTERS-1:0]        core_rdreq,
  input  logic [NUM_FILTERS*DWIDTH-1:0] core_wdata,
  input  logic [NUM_FILTERS-1:0]        core_wrreq,
  output logic [DWIDTH-1:0]             ff_wdata,
  output logic                          ff_wrreq,
  input  logic                          ff_full,
  output logic                          frame_done,
  output logic                          overflow_err,
  output logic                          sync_err
);

  localparam int AW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int PW  = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int TOT = FRAME_WORDS * NUM_FILTERS;
  localparam int WCW = (TOT > 1) ? $clog2(TOT) : 1;

  localparam logic [CW-1:0]  FULL_C  = CW'(BUF_DEPTH);
  localparam logic [CW-1:0]  STALL_C = CW'(STALL_LEVEL);
  localparam logic [PW-1:0]  LAST    = PW'(NUM_FILTERS - 1);
  localparam logic [WCW-1:0] TERM    = WCW'(TOT - 1);

  logic [DWIDTH-1:0] r_mem [NUM_FILTERS][BUF_DEPTH];
  logic [AW-1:0]     r_wptr [NUM_FILTERS];
  logic [AW-1:0]     r_rptr [NUM_FILTERS];
  logic [CW-1:0]     r_cnt  [NUM_FILTERS];
  logic [PW-1:0]     r_ptr;
  logic [WCW-1:0]    r_wcnt;
  logic [DWIDTH-1:0] r_wdata;
  logic              r_wrreq;
  logic              r_fdone;
  logic              r_ovf;
  logic              r_sync;

  logic [NUM_FILTERS-1:0] w_push;
  logic [NUM_FILTERS-1:0] w_full;
  logic                   w_stall;
  logic                   w_pop;
  logic [DWIDTH-1:0]      w_pop_data;

  // Buffer status, input-side stall and the drain decision.
  always_comb begin
    w_stall = 1'b0;
    for (int k = 0; k < NUM_FILTERS; k++) begin
      w_full[k] = (r_cnt[k] == FULL_C);
      w_push[k] = core_wrreq[k] & ~w_full[k];
      if (r_cnt[k] >= STALL_C) w_stall = 1'b1;
    end
    w_pop      = (r_cnt[r_ptr] != '0) & ~ff_full;
    w_pop_data = r_mem[r_ptr][r_rptr[r_ptr]];
  end

  assign core_empty = (|ff_empty) | w_stall;
  assign ff_rdreq   = (&core_rdreq) & ~(|ff_empty) & ~w_stall & ~reset;

  // Buffer storage; contents are don't-care while the count is zero.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_FILTERS; k++)
      if (w_push[k])
        r_mem[k][r_wptr[k]] <= core_wdata[k*DWIDTH +: DWIDTH];
  end

  // Per-filter pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
        r_cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + AW'(1);
        if (w_pop && r_ptr == PW'(k))
          r_rptr[k] <= r_rptr[k] + AW'(1);
        unique case ({w_push[k], w_pop && r_ptr == PW'(k)})
          2'b10:   r_cnt[k] <= r_cnt[k] + CW'(1);
          2'b01:   r_cnt[k] <= r_cnt[k] - CW'(1);
          default: r_cnt[k] <= r_cnt[k];
        endcase
      end
    end
  end

  // Drain pointer, frame word counter and registered output write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_wcnt  <= '0;
      r_wdata <= '0;
      r_wrreq <= 1'b0;
      r_fdone <= 1'b0;
    end else begin
      r_wrreq <= w_pop;
      r_fdone <= w_pop & (r_wcnt == TERM);
      if (w_pop) begin
        r_wdata <= w_pop_data;
        r_ptr   <= (r_ptr == LAST) ? '0 : r_ptr + PW'(1);
        r_wcnt  <= (r_wcnt == TERM) ? '0 : r_wcnt + WCW'(1);
      end
    end
  end

  // Sticky fault flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      if (|(core_wrreq & w_full)) r_ovf <= 1'b1;
      if (|core_rdreq && !(&core_rdreq)) r_sync <= 1'b1;
    end
  end

  assign ff_wdata     = r_wdata;
  assign ff_wrreq     = r_wrreq;
  assign frame_done   = r_fdone;
  assign overflow_err = r_ovf;
  assign sync_err     = r_sync;

endmodule

// File: tb/tb_conv2d_1_filter_scheduler.sv
// tb_conv2d_1_filter_scheduler: directed checks of ordering, latency,
// back-pressure, framing, fault flags and mid-drain reset.
module tb_conv2d_1_filter_scheduler;

  localparam int DW = 32;
  localparam int NF = 8;

  logic           clock;
  logic           reset;
  logic [7:0]     ff_empty;
  logic           ff_rdreq;
  logic           core_empty;
  logic [NF-1:0]  core_rdreq;
  logic [NF*DW-1:0] core_wdata;
  logic [NF-1:0]  core_wrreq;
  logic [DW-1:0]  ff_wdata;
  logic           ff_wrreq;
  logic           ff_full;
  logic           frame_done;
  logic           overflow_err;
  logic           sync_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] q_d [$];
  int          q_c [$];
  logic        q_f [$];

  conv2d_1_filter_scheduler #(
    .DWIDTH(DW), .NUM_FILTERS(NF), .BUF_DEPTH(8),
    .STALL_LEVEL(4), .FRAME_WORDS(2)
  ) dut (
    .clock(clock), .reset(reset), .ff_empty(ff_empty),
    .ff_rdreq(ff_rdreq), .core_empty(core_empty),
    .core_rdreq(core_rdreq), .core_wdata(core_wdata),
    .core_wrreq(core_wrreq), .ff_wdata(ff_wdata),
    .ff_wrreq(ff_wrreq), .ff_full(ff_full),
    .frame_done(frame_done), .overflow_err(overflow_err),
    .sync_err(sync_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset && ff_wrreq) begin
      q_d.push_back(ff_wdata);
      q_c.push_back(cyc);
      q_f.push_back(frame_done);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] qd(input int j);
    return (j < q_d.size()) ? q_d[j] : 32'hDEAD_BEEF;
  endfunction

  function automatic int qc(input int j);
    return (j < q_c.size()) ? q_c[j] : -1;
  endfunction

  function automatic logic qf(input int j);
    return (j < q_f.size()) ? q_f[j] : 1'bx;
  endfunction

  task automatic set_data(input logic [31:0] base);
    for (int k = 0; k < NF; k++)
      core_wdata[k*DW +: DW] = base + 32'(k);
  endtask

  task automatic clr_q();
    q_d.delete();
    q_c.delete();
    q_f.delete();
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    ff_empty   = 8'h00;
    core_rdreq = '1;
    core_wrreq = '0;
    core_wdata = '0;
    ff_full    = 1'b0;
    tick();
    tick();
    clr_q();
    reset = 1'b0;
    tick();
  endtask

  int c0;

  initial begin
    reset      = 1'b1;
    ff_empty   = 8'h01;
    core_rdreq = '1;
    core_wrreq = '0;
    core_wdata = '0;
    ff_full    = 1'b0;
    #2;
    chk("rst_wrreq", 32'(ff_wrreq), 32'd0);
    chk("rst_wdata", ff_wdata, 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(overflow_err), 32'd0);
    chk("rst_sync", 32'(sync_err), 32'd0);
    chk("rst_rdreq", 32'(ff_rdreq), 32'd0);
    chk("rst_cempty1", 32'(core_empty), 32'd1);
    ff_empty = 8'h00;
    #1;
    chk("rst_cempty0", 32'(core_empty), 32'd0);

    // latency and order for one word from every filter
    do_reset();
    chk("idle_rdreq", 32'(ff_rdreq), 32'd1);
    repeat (3) tick();
    set_data(32'h10);
    core_wrreq = '1;
    c0 = cyc;
    tick();
    core_wrreq = '0;
    repeat (12) tick();
    chk("t1_count", 32'(q_d.size()), 32'd8);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("t1_data%0d", j), qd(j), 32'h10 + 32'(j));
      chk($sformatf("t1_cyc%0d", j), 32'(qc(j)), 32'(c0 + 2 + j));
    end

    // empty buffer 0 blocks filter 3
    do_reset();
    core_wdata[3*DW +: DW] = 32'hA3;
    core_wrreq = 8'h08;
    tick();
    core_wrreq = '0;
    repeat (6) tick();
    chk("t2_block", 32'(q_d.size()), 32'd0);
    chk("t2_wrreq", 32'(ff_wrreq), 32'd0);
    core_wdata[0*DW +: DW] = 32'hA0;
    core_wdata[1*DW +: DW] = 32'hA1;
    core_wdata[2*DW +: DW] = 32'hA2;
    core_wrreq = 8'h07;
    tick();
    core_wrreq = '0;
    repeat (10) tick();
    chk("t2_count", 32'(q_d.size()), 32'd4);
    for (int j = 0; j < 4; j++)
      chk($sformatf("t2_data%0d", j), qd(j), 32'hA0 + 32'(j));

    // back-pressure: full output FIFO, 4 words per filter
    do_reset();
    ff_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < NF; k++)
        core_wdata[k*DW +: DW] = {16'(k), 16'(i)};
      core_wrreq = '1;
      tick();
    end
    core_wrreq = '0;
    chk("t3_cempty", 32'(core_empty), 32'd1);
    chk("t3_rdreq", 32'(ff_rdreq), 32'd0);
    chk("t3_nowr", 32'(q_d.size()), 32'd0);
    tick();
    ff_full = 1'b0;
    repeat (7) tick();
    chk("t3_stall_hold", 32'(core_empty), 32'd1);
    tick();
    chk("t3_stall_clr", 32'(core_empty), 32'd0);
    chk("t3_rdreq_on", 32'(ff_rdreq), 32'd1);
    repeat (30) tick();
    chk("t3_count", 32'(q_d.size()), 32'd32);
    for (int j = 0; j < 32; j++)
      chk($sformatf("t3_data%0d", j), qd(j),
          {16'(j % 8), 16'(j / 8)});
    chk("t3_ovf", 32'(overflow_err), 32'd0);

    // frame boundary with FRAME_WORDS=2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_data(32'h100 * 32'(i));
      core_wrreq = '1;
      tick();
    end
    core_wrreq = '0;
    repeat (36) tick();
    chk("t4_count", 32'(q_f.size()), 32'd32);
    for (int j = 0; j < 32; j++)
      chk($sformatf("t4_fd%0d", j), 32'(qf(j)),
          32'((j == 15) || (j == 31)));

    // fault flags
    do_reset();
    core_rdreq = 8'b0000_0001;
    #1;
    chk("t5_rdreq", 32'(ff_rdreq), 32'd0);
    tick();
    chk("t5_sync", 32'(sync_err), 32'd1);
    core_rdreq = '1;
    ff_full = 1'b1;
    core_wdata[0*DW +: DW] = 32'h77;
    core_wrreq = 8'h01;
    repeat (8) tick();
    chk("t5_ovf_pre", 32'(overflow_err), 32'd0);
    tick();
    core_wrreq = '0;
    chk("t5_ovf", 32'(overflow_err), 32'd1);
    ff_full = 1'b0;
    repeat (5) tick();
    chk("t5_sync_hold", 32'(sync_err), 32'd1);
    chk("t5_ovf_hold", 32'(overflow_err), 32'd1);
    reset = 1'b1;
    #1;
    chk("t5_sync_clr", 32'(sync_err), 32'd0);
    chk("t5_ovf_clr", 32'(overflow_err), 32'd0);

    // reset during a drain
    do_reset();
    set_data(32'h40);
    core_wrreq = '1;
    tick();
    set_data(32'h50);
    tick();
    core_wrreq = '0;
    tick();
    chk("t6_active", 32'(ff_wrreq), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_wrreq", 32'(ff_wrreq), 32'd0);
    chk("t6_wdata", ff_wdata, 32'd0);
    chk("t6_fdone", 32'(frame_done), 32'd0);
    chk("t6_cempty", 32'(core_empty), 32'd0);
    tick();
    clr_q();
    reset = 1'b0;
    repeat (4) tick();
    chk("t6_empty", 32'(q_d.size()), 32'd0);
    set_data(32'h20);
    core_wrreq = '1;
    tick();
    core_wrreq = '0;
    repeat (12) tick();
    chk("t6_count", 32'(q_d.size()), 32'd8);
    for (int j = 0; j < 8; j++)
      chk($sformatf("t6_data%0d", j), qd(j), 32'h20 + 32'(j));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv2d_1_filter_scheduler.md
# conv2d_1_filter_scheduler

Sequences a bank of NUM_FILTERS `featuremap_conv2d_1_filter*` cores that share one set of eight input channel FIFOs and one output FIFO. Pops the shared input FIFOs in lockstep for all cores. Buffers each core's non-stallable output stream and drains the streams in strict filter order (f0, f1, …, fN-1, f0, …) into the output FIFO. Applies input back-pressure when any per-filter buffer nears full, and marks frame boundaries.

## Interface
- DWIDTH, 32, data word width
- NUM_FILTERS, 8, number of filter cores served
- BUF_DEPTH, 8, per-filter output buffer depth (power of 2)
- STALL_LEVEL, 4, buffer occupancy at or above which input pops stall
- FRAME_WORDS, 1024, output words per filter per frame

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ff_empty  in  8  empty flags of the shared input channel FIFOs 0..7
- ff_rdreq  out  1  pop strobe to all eight input FIFOs
- core_empty  out  1  empty flag broadcast to every core's data_fifo_empty0..7
- core_rdreq  in  NUM_FILTERS  rdreq from each core
- core_wdata  in  NUM_FILTERS*DWIDTH  data_out of each core; filter k occupies bits [k*DWIDTH +: DWIDTH]
- core_wrreq  in  NUM_FILTERS  valid_out from each core
- ff_wdata  out  DWIDTH  output FIFO write data, registered
- ff_wrreq  out  1  output FIFO write strobe, registered
- ff_full  in  1  output FIFO full
- frame_done  out  1  one-cycle pulse with the last write of a frame
- overflow_err  out  1  sticky: a core wrote into a full buffer
- sync_err  out  1  sticky: core_rdreq bits disagreed

## Operation
- stall = 1 when any per-filter buffer count >= STALL_LEVEL.
- core_empty = (|ff_empty) | stall. The combinational path is required so that no core requests while the scheduler is stalled.
- ff_rdreq = (&core_rdreq) & ~(|ff_empty) & ~stall, combinational.
- sync_err sets when core_rdreq is neither all-0 nor all-1. It clears only on reset.
- Per-filter buffer: FIFO of BUF_DEPTH words with count 0..BUF_DEPTH.
  - core_wrreq[k] pushes core_wdata slice k.
  - A push into a full buffer drops the word and sets overflow_err (sticky).
  - A push and a pop in the same cycle leave the count unchanged.
- Drain pointer ptr is 0..NUM_FILTERS-1; reset value 0.
- Each cycle, if buffer[ptr] is non-empty and ff_full = 0:
  - pop buffer[ptr];
  - register its word onto ff_wdata with ff_wrreq = 1;
  - ptr advances (NUM_FILTERS-1 wraps to 0).
- Otherwise ff_wrreq = 0, ff_wdata holds its last value, and ptr holds. There is no skipping: an empty buffer[ptr] blocks the others.
- Word counter is 0..FRAME_WORDS*NUM_FILTERS-1 and increments on each issued write.
  - The write issued at the terminal count drives frame_done = 1 in the same cycle as that ff_wrreq.
  - The counter then wraps to 0.
- Reset mid-operation: all buffers and counters are emptied, ptr returns to 0, and in-flight words are discarded.

## Timing
- Reset values: ff_wrreq 0, ff_wdata 0, frame_done 0, overflow_err 0, sync_err 0, all counts 0, ptr 0.
- ff_rdreq and core_empty follow reset combinationally: ff_rdreq 0. core_empty reflects ff_empty with stall = 0.
- Latency: a core_wrreq[k] in cycle t (buffer k empty, ptr = k, ff_full = 0) produces ff_wrreq high in cycle t+2.
- ff_full is sampled in the cycle the pop is decided. The output FIFO must provide at least one word of slack for the registered write.
- Stall asserts in the cycle after the count reaches STALL_LEVEL. Cores in flight may push up to BUF_DEPTH-STALL_LEVEL further words without overflow.
- Sustained throughput is 1 output word per cycle while ff_full = 0.

## Test plan
- Reset, then all core_wrreq pulse once in cycle 5 with data 0x10+k.
  - ff_wrreq is high in cycles 7..14.
  - ff_wdata sequence is 0x10..0x17.
- Only filter 3 writes (data 0xA3); filters 0–2 are idle.
  - No ff_wrreq while buffer 0 is empty.
  - Then filters 0–2 write: output order is f0, f1, f2, 0xA3.
- ff_full = 1 while every core pushes 4 words.
  - stall and core_empty go 1, ff_rdreq = 0.
  - After ff_full drops, 32 words drain in strict order and stall clears at count < 4.
- FRAME_WORDS = 2, NUM_FILTERS = 8.
  - frame_done pulses with exactly the 16th and 32nd ff_wrreq.
- Fault cases:
  - core_rdreq = 8'b0000_0001 -> sync_err = 1 and ff_rdreq = 0.
  - A 9th push into a full buffer -> overflow_err = 1.
  - Both flags hold until reset.
- Assert reset during a drain with words pending.
  - All outputs return to 0 immediately and the buffers read as empty.
  - Post-reset traffic starts at filter 0.
